// File: rtl/txn_sequencer.sv
// rtl/txn_sequencer.sv - round-robin launcher for a shared valid/a/b channel with fixed a-to-b delay.
// Optional checkers compile in when TXN_SEQUENCER_ASSERT_EN is defined.
module txn_sequencer #(
  parameter int N_REQ   = 4,
  parameter int DELAY   = 3,
  parameter int MAX_OUT = 3,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [N_REQ-1:0]               req,
  output logic [N_REQ-1:0]               gnt,
  output logic                           valid,
  output logic                           a,
  output logic [ID_W-1:0]                a_id,
  output logic                           b,
  output logic [ID_W-1:0]                b_id,
  output logic [$clog2(MAX_OUT+1)-1:0]   out_cnt
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [N_REQ-1:0] gnt_q;
  logic             valid_q;
  logic [ID_W-1:0]  a_id_q;
  logic             b_q;
  logic [ID_W-1:0]  b_id_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic [DELAY-1:0] dl_vld_q;
  logic [ID_W-1:0]  dl_id_q [DELAY];

  logic             found;
  logic [ID_W-1:0]  pick;
  logic             retire;
  logic             launch;

  // First requester at or after the pointer, wrapping past N_REQ-1.
  always_comb begin
    logic [ID_W-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // A slot frees at the same edge the oldest entry leaves for the b register.
  assign retire = dl_vld_q[DELAY-1];
  assign launch = enable && found && ((out_cnt_q < CNT_W'(MAX_OUT)) || retire);
  assign ptr_d  = (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      a_id_q    <= '0;
      b_q       <= 1'b0;
      b_id_q    <= '0;
      out_cnt_q <= '0;
      ptr_q     <= '0;
      dl_vld_q  <= '0;
      for (int i = 0; i < DELAY; i++) dl_id_q[i] <= '0;
    end else begin
      gnt_q   <= launch ? (N_REQ'(1) << pick) : '0;
      valid_q <= launch;
      if (launch) begin
        a_id_q <= pick;
        ptr_q  <= ptr_d;
      end
      dl_vld_q[0] <= launch;
      dl_id_q[0]  <= pick;
      for (int i = 1; i < DELAY; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_id_q[i]  <= dl_id_q[i-1];
      end
      b_q <= retire;
      if (retire) b_id_q <= dl_id_q[DELAY-1];
      case ({launch, retire})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign valid   = valid_q;
  assign a       = valid_q;
  assign a_id    = a_id_q;
  assign b       = b_q;
  assign b_id    = b_id_q;
  assign out_cnt = out_cnt_q;

`ifdef TXN_SEQUENCER_ASSERT_EN
  ap_proto: assert property (@(posedge clk) disable iff (!rst_n) valid |-> a ##DELAY b)
    else $error("txn_sequencer: b did not follow a after DELAY cycles");
  ap_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
    else $error("txn_sequencer: gnt not one-hot");
  ap_cnt: assert property (@(posedge clk) disable iff (!rst_n) out_cnt <= CNT_W'(MAX_OUT))
    else $error("txn_sequencer: out_cnt above MAX_OUT");
  for (genvar g = 0; g < N_REQ; g++) begin : g_gnt_chk
    ap_gnt: assert property (@(posedge clk) disable iff (!rst_n) gnt[g] |-> $past(req[g]))
      else $error("txn_sequencer: grant without request");
  end
`endif

endmodule

// File: tb/tb_txn_sequencer.sv
// tb/tb_txn_sequencer.sv - directed bench for txn_sequencer with a b-completion scoreboard.
module tb_txn_sequencer;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] req1 = '0;

  logic [3:0] gnt, gnt1;
  logic       valid, a, b, valid1, a1, b1;
  logic [1:0] a_id, b_id, a_id1, b_id1;
  logic [1:0] out_cnt;
  logic       out_cnt1;

  txn_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .gnt(gnt),
    .valid(valid), .a(a), .a_id(a_id), .b(b), .b_id(b_id), .out_cnt(out_cnt)
  );

  txn_sequencer #(.MAX_OUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req1), .gnt(gnt1),
    .valid(valid1), .a(a1), .a_id(a_id1), .b(b1), .b_id(b_id1), .out_cnt(out_cnt1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nfail = 0;

  typedef struct { int id; int due; } exp_t;
  exp_t bq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_launch(input int id, input int cnt);
    exp_t e;
    chk("gnt", 32'(gnt), 32'(1 << id));
    chk("valid", 32'(valid), 1);
    chk("a", 32'(a), 1);
    chk("a_id", 32'(a_id), id);
    chk("out_cnt", 32'(out_cnt), cnt);
    e.id = id;
    e.due = cyc + D;
    bq.push_back(e);
  endtask

  task automatic expect_idle(input int cnt);
    chk("idle_a", 32'(a), 0);
    chk("idle_valid", 32'(valid), 0);
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_out_cnt", 32'(out_cnt), cnt);
  endtask

  // Completion side of the scoreboard: every b must match the head entry exactly on its due cycle.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (bq.size() != 0 && bq[0].due == cyc) begin
        e = bq.pop_front();
        chk("b", 32'(b), 1);
        chk("b_id", 32'(b_id), e.id);
      end else if (b) begin
        chk("b_spurious", 32'(b), 0);
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_a", 32'(a), 0);
    chk("rst_a_id", 32'(a_id), 0);
    chk("rst_b", 32'(b), 0);
    chk("rst_b_id", 32'(b_id), 0);
    chk("rst_out_cnt", 32'(out_cnt), 0);
    chk("rst_out_cnt1", 32'(out_cnt1), 0);
    rst_n = 1'b1;
    tick();
    expect_idle(0);

    // Single request
    req = 4'b0100;
    tick();
    req = 4'b0000;
    expect_launch(2, 1);
    tick(); expect_idle(1);
    tick(); expect_idle(1);
    tick(); expect_idle(0);
    chk("single_b", 32'(b), 1);
    chk("single_b_id", 32'(b_id), 2);

    // Round-robin full pipeline; pointer sits at 3 after the single launch
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      expect_launch((3 + k) % 4, (k < 3) ? k + 1 : 3);
      if (k >= 3) chk("rr_b_with_a", 32'(b), 1);
    end
    req = 4'b0000;
    tick(); expect_idle(2);
    tick(); expect_idle(1);
    tick(); expect_idle(0);
    chk("a_id_hold", 32'(a_id), 2);

    // Enable gating
    req = 4'b0001;
    tick();
    expect_launch(0, 1);
    enable = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      expect_idle((i < 3) ? 1 : 0);
    end
    enable = 1'b1;
    tick();
    expect_launch(0, 1);
    req = 4'b0000;
    tick(); expect_idle(1);
    tick(); expect_idle(1);
    tick(); expect_idle(0);

    // Mid-flight reset discards pending completions and the pointer
    req = 4'b0110;
    tick();
    expect_launch(1, 1);
    req = 4'b0100;
    tick();
    expect_launch(2, 2);
    req = 4'b0000;
    tick();
    expect_idle(2);
    rst_n = 1'b0;
    #2;
    chk("mrst_gnt", 32'(gnt), 0);
    chk("mrst_a", 32'(a), 0);
    chk("mrst_a_id", 32'(a_id), 0);
    chk("mrst_b", 32'(b), 0);
    chk("mrst_out_cnt", 32'(out_cnt), 0);
    bq.delete();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_idle(0);
      chk("mrst_no_b", 32'(b), 0);
    end
    req = 4'b1001;
    tick();
    expect_launch(0, 1);
    req = 4'b1000;
    tick();
    expect_launch(3, 2);
    req = 4'b0000;
    tick(); expect_idle(2);
    tick(); expect_idle(1);
    tick(); expect_idle(0);

    // Throttle with MAX_OUT = 1
    req1 = 4'b0011;
    tick();
    chk("thr_a0", 32'(a1), 1);
    chk("thr_gnt0", 32'(gnt1), 32'h1);
    chk("thr_id0", 32'(a_id1), 0);
    chk("thr_cnt0", 32'(out_cnt1), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("thr_gap_a", 32'(a1), 0);
      chk("thr_gap_cnt", 32'(out_cnt1), 1);
    end
    tick();
    chk("thr_a1", 32'(a1), 1);
    chk("thr_gnt1", 32'(gnt1), 32'h2);
    chk("thr_id1", 32'(a_id1), 1);
    chk("thr_b1", 32'(b1), 1);
    chk("thr_bid1", 32'(b_id1), 0);
    chk("thr_cnt1", 32'(out_cnt1), 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("thr_gap_a", 32'(a1), 0);
    end
    tick();
    chk("thr_a2", 32'(a1), 1);
    chk("thr_id2", 32'(a_id1), 0);
    chk("thr_b2", 32'(b1), 1);
    chk("thr_bid2", 32'(b_id1), 1);
    req1 = 4'b0000;
    tick();
    tick();
    chk("thr_quiet_b", 32'(b1), 0);
    tick();
    chk("thr_b3", 32'(b1), 1);
    chk("thr_bid3", 32'(b_id1), 0);
    chk("thr_cnt_end", 32'(out_cnt1), 0);

    tick();
    chk("bq_empty", 32'(bq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
